// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer: records the per-stage PC vector of a pipeline into a
// circular buffer each cycle while a capture is active. The buffer freezes
// POST_CNT entries after the cycle whose TRIG_STAGE PC matches trig_pc, which
// leaves a pre- and post-trigger history in the buffer.
// Optional build macro TRACE_DEDUP_EN: skips writes whose PC vector equals the
// most recently written entry, so pipeline stalls do not use up buffer space.
module pipeline_trace_buffer #(
  parameter int STAGES     = 5,
  parameter int PC_W       = 32,
  parameter int DEPTH      = 16,
  parameter int POST_CNT   = 4,
  parameter int TRIG_STAGE = 4,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int DATA_W    = STAGES * PC_W
) (
  input  logic              clk,
  input  logic              resten,
  input  logic [DATA_W-1:0] stage_pc,
  input  logic              arm,
  input  logic              stop,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        state,
  output logic              triggered,
  output logic [ADDR_W-1:0] trig_idx,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   fill_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   FILL_MAX  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] POST_INIT = (ADDR_W)'(POST_CNT);
  localparam logic [ADDR_W-1:0] PTR_ONE   = (ADDR_W)'(1);
  localparam logic [ADDR_W:0]   FILL_ONE  = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] trig_idx_q, trig_idx_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
  logic              triggered_q, triggered_d;
  logic [DATA_W-1:0] rd_data_q;

  logic trig_hit_s;
  logic dup_s;
  logic capture_s;
  logic wr_en_s;
  logic restart_s;

  assign trig_hit_s = (stage_pc[TRIG_STAGE*PC_W +: PC_W] == trig_pc);
  assign capture_s  = (state_q == ST_ARMED) || (state_q == ST_POST);
  // A write never happens in the stop cycle, nor while reset is applied.
  assign wr_en_s    = capture_s && !stop && !dup_s && !resten;
  // arm only restarts from a quiescent state; it is ignored mid-capture.
  assign restart_s  = arm && !stop && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef TRACE_DEDUP_EN
  logic [DATA_W-1:0] last_q, last_d;
  logic              last_vld_q, last_vld_d;

  // A cycle is a stall duplicate only if an entry has been written since arm.
  assign dup_s = last_vld_q && (stage_pc == last_q);

  // Track the most recently written entry; arm forgets it.
  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (restart_s) begin
      last_vld_d = 1'b0;
    end else if (wr_en_s) begin
      last_d     = stage_pc;
      last_vld_d = 1'b1;
    end else begin
      last_vld_d = last_vld_q;
    end
  end

  // Last-entry registers.
  always_ff @(posedge clk) begin
    if (resten) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign dup_s = 1'b0;
`endif

  // Next-state, pointer, counter and trigger-index computation.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    trig_idx_d = trig_idx_q;
    post_cnt_d = post_cnt_q;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (fill_cnt_q != FILL_MAX) begin
        fill_cnt_d = fill_cnt_q + FILL_ONE;
      end else begin
        fill_cnt_d = fill_cnt_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (stop) begin
      // stop wins over arm and trigger; pointers and trig_idx are kept.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d    = ST_ARMED;
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
          end else begin
            state_d = state_q;
          end
        end
        ST_ARMED: begin
          if (trig_hit_s) begin
            // On a skipped duplicate the trigger entry is the one already written.
            trig_idx_d = dup_s ? (wr_ptr_q - PTR_ONE) : wr_ptr_q;
            if (POST_CNT == 32'sd0) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_POST;
              post_cnt_d = POST_INIT;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_POST: begin
          if (wr_en_s) begin
            post_cnt_d = post_cnt_q - PTR_ONE;
            if (post_cnt_q == PTR_ONE) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
            end
          end else begin
            post_cnt_d = post_cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    triggered_d = (state_d == ST_POST) || (state_d == ST_DONE);
  end

  // Control state and status registers.
  always_ff @(posedge clk) begin
    if (resten) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      trig_idx_q  <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      trig_idx_q  <= trig_idx_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
    end
  end

  // Trace storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_q] <= stage_pc;
    end
  end

  // Registered read port; a same-address write in this cycle is not visible.
  always_ff @(posedge clk) begin
    if (resten) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data   = rd_data_q;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign trig_idx  = trig_idx_q;
  assign wr_ptr    = wr_ptr_q;
  assign fill_cnt  = fill_cnt_q;

endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
- Synthesizable, parametrised pipeline trace capture unit.
- Records the per-stage PC vector (IF..WB, or any stage count) each cycle into a circular buffer.
- Freezes the buffer a programmable number of entries after a PC-match trigger.
- Sits beside pipeline_cpu and replaces ad-hoc waveform inspection with a readable pre/post-trigger history, usable in simulation and on board.

Parameters:
- STAGES, 5: number of pipeline stages traced.
- PC_W, 32: width of each stage PC.
- DEPTH, 16: buffer entries; power of 2, at least 4. ADDR_W = clog2(DEPTH).
- POST_CNT, 4: entries recorded after the trigger entry; legal range 0..DEPTH-1.
- TRIG_STAGE, 4: stage index (0 = IF) whose PC is compared against trig_pc.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resten  in  1  synchronous active-high reset.
- stage_pc  in  STAGES*PC_W  stage PCs; stage i occupies bits [i*PC_W +: PC_W].
- arm  in  1  one-cycle pulse; start or restart a capture.
- stop  in  1  abort capture; return to IDLE.
- trig_pc  in  PC_W  trigger compare value.
- rd_addr  in  ADDR_W  absolute buffer read address.
- rd_data  out  STAGES*PC_W  registered read data.
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- triggered  out  1  high in POST and DONE.
- trig_idx  out  ADDR_W  buffer address of the trigger entry.
- wr_ptr  out  ADDR_W  next write address.
- fill_cnt  out  ADDR_W+1  valid entries; saturates at DEPTH.

Behaviour:
- Reset: state=IDLE, triggered=0, trig_idx=0, wr_ptr=0, fill_cnt=0, rd_data=0, post counter=0. Memory contents are not cleared.
- Write: in ARMED and POST, every cycle writes stage_pc to mem[wr_ptr] and increments wr_ptr modulo DEPTH (wraps DEPTH-1 -> 0). fill_cnt increments per write, saturating at DEPTH.
- IDLE: no writes. arm=1 -> ARMED next cycle, with wr_ptr=0, fill_cnt=0, triggered=0. The arm cycle itself writes nothing.
- ARMED: if stage_pc[TRIG_STAGE] == trig_pc, the current entry is written and trig_idx is set to the current wr_ptr.
  - POST_CNT=0 -> DONE.
  - Otherwise -> POST, with post counter = POST_CNT.
- POST: each write decrements the post counter. The write made with the counter at 1 is the last one; the next state is DONE. Trigger compares are ignored in POST.
- DONE: no writes; buffer frozen. arm=1 -> ARMED, same clearing as from IDLE.
- arm while ARMED or POST: ignored.
- stop=1 in any state -> IDLE next cycle, with no write in that cycle. Pointers and trig_idx hold their values. stop has priority over arm and trigger.
- Total entries on a completed capture: trigger entry + POST_CNT. The oldest valid entry is at (trig_idx + POST_CNT + 1 - fill_cnt) mod DEPTH.
- Read: rd_data = mem[rd_addr] registered, 1-cycle latency, in every state.
  - Read and write to the same address in the same cycle returns the old data.
- resten mid-capture: outputs return to reset values next cycle. The capture is lost.

Optional Feature:
- TRACE_DEDUP_EN defined:
  - In ARMED/POST, a write is skipped when stage_pc equals the most recently written entry (pipeline stall).
  - Skipped cycles do not advance wr_ptr, fill_cnt or the post counter.
  - The trigger is still evaluated on skipped cycles. On a match, no new entry is written and trig_idx = wr_ptr-1.
  - The last-entry register is cleared by arm.
- TRACE_DEDUP_EN undefined: every ARMED/POST cycle writes, as above.

Test Plan:
All scenarios use STAGES=5, PC_W=32, DEPTH=16, POST_CNT=4, TRIG_STAGE=4.
- Reset: hold resten 2 cycles -> state=0, wr_ptr=0, fill_cnt=0, rd_data=0, triggered=0.
- Basic trigger:
  - Stimulus: arm, then WB PC increments by 4 from 0x0 per cycle; trig_pc=0x20.
  - Required: trig_idx=8; DONE 5 writes later with wr_ptr=13, fill_cnt=13.
  - mem[8] WB field = 0x20; rd_addr=12 returns WB 0x30 one cycle later.
- Wrap:
  - Stimulus: trig_pc=0x64 (WB reaches it at write 25).
  - Required: trig_idx=9, final wr_ptr=14, fill_cnt=16; oldest entry at address 14 holds WB 0x38.
- Stop/re-arm:
  - Stimulus: stop asserted in POST, then arm.
  - Required: IDLE with wr_ptr held; after arm, wr_ptr=0, fill_cnt=0, triggered=0.
  - arm pulses in POST or ARMED are ignored.
- Simultaneous stop and trigger match in ARMED -> IDLE, no write, trig_idx unchanged.
- Dedup (TRACE_DEDUP_EN): same stage_pc held 3 cycles -> only 1 entry written; post counter decrements once across those cycles.
